// File: rtl/sfilter_control_pkg.sv
// Shared defaults and FSM encodings for the LPC synthesis-filter sequencer.
// Frame geometry defaults match the inverse-filter control.
package sfilter_control_pkg;

  localparam int SF_FRAME_LEN = 160;
  localparam int SF_ORDER     = 10;
  localparam int SF_ADDR_W    = 8;

  typedef enum logic [2:0] {
    SF_IDLE,
    SF_ISSUE_RES,
    SF_ISSUE_TAP,
    SF_DRAIN,
    SF_WRITE
  } sf_state_t;

endpackage

// File: rtl/sfilter_control_if.sv
// Handshake and RAM/MAC strobe bundle of the synthesis-filter sequencer.
// master: the sequencer (drives ready, addresses, strobes); slave: requester/datapath.
interface sfilter_control_if #(
  parameter int ADDR_W = 8,
  parameter int ORDER  = 10
);

  logic              start;
  logic              ready;
  logic [ADDR_W-1:0] res_raddr;
  logic [ADDR_W-1:0] y_raddr;
  logic [ORDER-1:0]  a_rsel;
  logic              acc_load;
  logic              mac_en;
  logic [ADDR_W-1:0] y_waddr;
  logic              y_wen;
  logic              next_sample;
  logic              done;

  modport master (
    input  start,
    output ready, res_raddr, y_raddr, a_rsel,
    output acc_load, mac_en, y_waddr, y_wen,
    output next_sample, done
  );

  modport slave (
    output start,
    input  ready, res_raddr, y_raddr, a_rsel,
    input  acc_load, mac_en, y_waddr, y_wen,
    input  next_sample, done
  );

endinterface

// File: rtl/sfilter_control_tap_seq.sv
// Tap sequencer: counter k, limit m=min(n,ORDER), history address and
// one-cycle-delayed acc_load/mac_en/a_rsel strobes.
// Ports: clk, reset (sync, active-low), n, load (ISSUE_RES), step (ISSUE_TAP),
// m_zero, last_tap, y_raddr, a_rsel, acc_load, mac_en.
module sfilter_control_tap_seq #(
  parameter int ORDER  = 10,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] n,
  input  logic              load,
  input  logic              step,
  output logic              m_zero,
  output logic              last_tap,
  output logic [ADDR_W-1:0] y_raddr,
  output logic [ORDER-1:0]  a_rsel,
  output logic              acc_load,
  output logic              mac_en
);

  localparam int KW = $clog2(ORDER + 1);
  localparam logic [ORDER-1:0] SEL1 = ORDER'(1);

  logic [KW-1:0] k;
  logic [KW-1:0] m;

  assign m        = (n < ADDR_W'(ORDER)) ? KW'(n) : KW'(ORDER);
  assign m_zero   = (m == '0);
  assign last_tap = (k == m);

  // Strobes trail their address by one cycle to match RAM read latency.
  always_ff @(posedge clk) begin
    if (!reset) begin
      k        <= '0;
      y_raddr  <= '0;
      a_rsel   <= '0;
      acc_load <= 1'b0;
      mac_en   <= 1'b0;
    end else begin
      acc_load <= load;
      mac_en   <= step;
      a_rsel   <= step ? (SEL1 << (k - KW'(1))) : '0;
      if (load && !m_zero) begin
        k       <= KW'(1);
        y_raddr <= n - ADDR_W'(1);
      end else if (step && !last_tap) begin
        k       <= k + KW'(1);
        y_raddr <= n - ADDR_W'(k) - ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/sfilter_control.sv
// Sequencer for the LPC all-pole synthesis filter: y[n]=e[n]+sum a[k]y[n-k].
// Ports: clk, reset (sync, active-low), bus (sfilter_control_if.master).
module sfilter_control
  import sfilter_control_pkg::*;
#(
  parameter int FRAME_LEN = SF_FRAME_LEN,
  parameter int ORDER     = SF_ORDER,
  parameter int ADDR_W    = SF_ADDR_W
) (
  input logic                clk,
  input logic                reset,
  sfilter_control_if.master  bus
);

  sf_state_t         state;
  logic [ADDR_W-1:0] n;
  logic [ADDR_W-1:0] res_raddr;
  logic [ADDR_W-1:0] y_waddr;
  logic              ready;
  logic              y_wen;
  logic              next_sample;
  logic              done;

  logic              m_zero;
  logic              last_tap;
  logic              last_n;
  logic [ADDR_W-1:0] y_raddr;
  logic [ORDER-1:0]  a_rsel;
  logic              acc_load;
  logic              mac_en;

  assign last_n = (n == ADDR_W'(FRAME_LEN - 1));

  sfilter_control_tap_seq #(
    .ORDER  (ORDER),
    .ADDR_W (ADDR_W)
  ) u_tap (
    .clk      (clk),
    .reset    (reset),
    .n        (n),
    .load     (state == SF_ISSUE_RES),
    .step     (state == SF_ISSUE_TAP),
    .m_zero   (m_zero),
    .last_tap (last_tap),
    .y_raddr  (y_raddr),
    .a_rsel   (a_rsel),
    .acc_load (acc_load),
    .mac_en   (mac_en)
  );

  // Outputs are set on the edge entering the state they belong to.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= SF_IDLE;
      n           <= '0;
      res_raddr   <= '0;
      y_waddr     <= '0;
      ready       <= 1'b1;
      y_wen       <= 1'b0;
      next_sample <= 1'b0;
      done        <= 1'b0;
    end else begin
      y_wen       <= 1'b0;
      next_sample <= 1'b0;
      done        <= 1'b0;
      unique case (state)
        SF_IDLE: begin
          if (bus.start) begin
            state     <= SF_ISSUE_RES;
            n         <= '0;
            res_raddr <= '0;
            ready     <= 1'b0;
          end
        end
        SF_ISSUE_RES: begin
          state <= m_zero ? SF_DRAIN : SF_ISSUE_TAP;
        end
        SF_ISSUE_TAP: begin
          if (last_tap) state <= SF_DRAIN;
        end
        SF_DRAIN: begin
          state       <= SF_WRITE;
          y_wen       <= 1'b1;
          next_sample <= 1'b1;
          y_waddr     <= n;
          done        <= last_n;
        end
        SF_WRITE: begin
          if (last_n) begin
            state <= SF_IDLE;
            ready <= 1'b1;
          end else begin
            state     <= SF_ISSUE_RES;
            n         <= n + ADDR_W'(1);
            res_raddr <= n + ADDR_W'(1);
          end
        end
        default: state <= SF_IDLE;
      endcase
    end
  end

  assign bus.ready       = ready;
  assign bus.res_raddr   = res_raddr;
  assign bus.y_raddr     = y_raddr;
  assign bus.a_rsel      = a_rsel;
  assign bus.acc_load    = acc_load;
  assign bus.mac_en      = mac_en;
  assign bus.y_waddr     = y_waddr;
  assign bus.y_wen       = y_wen;
  assign bus.next_sample = next_sample;
  assign bus.done        = done;

endmodule

// File: tb/tb_sfilter_control.sv
// Directed self-checking bench for sfilter_control.
// Inputs change and outputs are sampled on the falling edge.
module tb_sfilter_control;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sfilter_control_if #(.ADDR_W(8), .ORDER(10)) bus ();

  sfilter_control #(
    .FRAME_LEN (160),
    .ORDER     (10),
    .ADDR_W    (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic abort_frame;
    bus.start = 1'b0;
    reset = 1'b0;
    tick;
    reset = 1'b1;
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (bus.ready !== 1'b1 || bus.res_raddr !== 8'h0 ||
        bus.y_raddr !== 8'h0 || bus.a_rsel !== 10'h0 ||
        bus.acc_load !== 1'b0 || bus.mac_en !== 1'b0 ||
        bus.y_waddr !== 8'h0 || bus.y_wen !== 1'b0 ||
        bus.next_sample !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL %s: ready=%b res=%h yr=%h sel=%h acc=%b mac=%b ywa=%h wen=%b ns=%b done=%b, need ready=1 rest 0",
               name, bus.ready, bus.res_raddr, bus.y_raddr, bus.a_rsel,
               bus.acc_load, bus.mac_en, bus.y_waddr, bus.y_wen,
               bus.next_sample, bus.done);
    end
  endtask

  task automatic run_frame(input bit hold, output int cyc,
                           output int wens, output int oerr,
                           output int ovl, output int dones);
    bus.start = 1'b1;
    tick;
    if (!hold) bus.start = 1'b0;
    cyc = 1; wens = 0; oerr = 0; ovl = 0; dones = 0;
    while (cyc < 3000) begin
      if (bus.acc_load && bus.mac_en) ovl++;
      if (bus.y_wen && (bus.acc_load || bus.mac_en)) ovl++;
      if (bus.y_wen) begin
        if (bus.y_waddr !== 8'(wens) || bus.next_sample !== 1'b1) oerr++;
        wens++;
      end else if (bus.next_sample) begin
        oerr++;
      end
      if (bus.done) begin
        dones++;
        break;
      end
      tick;
      cyc++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.start = 1'b1;
    tick;
    tick;
    check_idle_outputs("reset_outputs");
    bus.start = 1'b0;
    reset = 1'b1;
    tick;
    check_idle_outputs("reset_start_ignored");
  endtask

  task automatic test_first_sample;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    checks++;
    if (bus.ready !== 1'b0 || bus.res_raddr !== 8'd0 || bus.acc_load !== 1'b0) begin
      errors++;
      $display("FAIL first_issue_res: ready=%b res=%0d acc=%b, need 0/0/0",
               bus.ready, bus.res_raddr, bus.acc_load);
    end
    tick;
    checks++;
    if (bus.acc_load !== 1'b1 || bus.mac_en !== 1'b0 || bus.y_wen !== 1'b0) begin
      errors++;
      $display("FAIL first_acc_load: acc=%b mac=%b wen=%b, need 1/0/0",
               bus.acc_load, bus.mac_en, bus.y_wen);
    end
    tick;
    checks++;
    if (bus.y_wen !== 1'b1 || bus.y_waddr !== 8'd0 ||
        bus.next_sample !== 1'b1 || bus.done !== 1'b0 || bus.acc_load !== 1'b0) begin
      errors++;
      $display("FAIL first_write: wen=%b ywa=%0d ns=%b done=%b acc=%b, need 1/0/1/0/0",
               bus.y_wen, bus.y_waddr, bus.next_sample, bus.done, bus.acc_load);
    end
    tick;
    checks++;
    if (bus.res_raddr !== 8'd1 || bus.y_wen !== 1'b0) begin
      errors++;
      $display("FAIL second_issue_res: res=%0d wen=%b, need 1/0",
               bus.res_raddr, bus.y_wen);
    end
    abort_frame;
  endtask

  task automatic test_tap_sample;
    int cyc;
    logic [9:0] exp_sel;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    cyc = 1;
    while (bus.res_raddr !== 8'd12 && cyc < 300) begin
      tick;
      cyc++;
    end
    checks++;
    if (cyc != 102) begin
      errors++;
      $display("FAIL tap_n12_start: cycle=%0d, need 102", cyc);
    end
    tick;
    checks++;
    if (bus.y_raddr !== 8'd11 || bus.acc_load !== 1'b1 ||
        bus.mac_en !== 1'b0 || bus.a_rsel !== 10'h0) begin
      errors++;
      $display("FAIL tap_first: yr=%0d acc=%b mac=%b sel=%h, need 11/1/0/000",
               bus.y_raddr, bus.acc_load, bus.mac_en, bus.a_rsel);
    end
    for (int j = 1; j <= 9; j++) begin
      tick;
      exp_sel = 10'd1 << (j - 1);
      checks++;
      if (bus.y_raddr !== 8'(11 - j) || bus.mac_en !== 1'b1 ||
          bus.acc_load !== 1'b0 || bus.a_rsel !== exp_sel) begin
        errors++;
        $display("FAIL tap_step%0d: yr=%0d mac=%b acc=%b sel=%h, need %0d/1/0/%h",
                 j, bus.y_raddr, bus.mac_en, bus.acc_load, bus.a_rsel,
                 11 - j, exp_sel);
      end
    end
    tick;
    checks++;
    if (bus.mac_en !== 1'b1 || bus.a_rsel !== 10'h200 || bus.y_wen !== 1'b0) begin
      errors++;
      $display("FAIL tap_drain: mac=%b sel=%h wen=%b, need 1/200/0",
               bus.mac_en, bus.a_rsel, bus.y_wen);
    end
    tick;
    checks++;
    if (bus.y_wen !== 1'b1 || bus.y_waddr !== 8'd12 || bus.mac_en !== 1'b0 ||
        bus.a_rsel !== 10'h0 || bus.y_raddr !== 8'd2) begin
      errors++;
      $display("FAIL tap_write: wen=%b ywa=%0d mac=%b sel=%h yr=%0d, need 1/12/0/000/2",
               bus.y_wen, bus.y_waddr, bus.mac_en, bus.a_rsel, bus.y_raddr);
    end
    abort_frame;
  endtask

  task automatic test_full_frame;
    int cyc, wens, oerr, ovl, dones;
    run_frame(1'b0, cyc, wens, oerr, ovl, dones);
    checks++;
    if (cyc != 2025 || dones != 1) begin
      errors++;
      $display("FAIL frame_done_cycle: cycle=%0d dones=%0d, need 2025/1", cyc, dones);
    end
    checks++;
    if (wens != 160 || oerr != 0) begin
      errors++;
      $display("FAIL frame_writes: wens=%0d order_err=%0d, need 160/0", wens, oerr);
    end
    checks++;
    if (ovl != 0) begin
      errors++;
      $display("FAIL frame_strobe_overlap: overlaps=%0d, need 0", ovl);
    end
    tick;
    checks++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.y_wen !== 1'b0) begin
      errors++;
      $display("FAIL frame_ready_after: ready=%b done=%b wen=%b, need 1/0/0",
               bus.ready, bus.done, bus.y_wen);
    end
  endtask

  task automatic test_mid_reset;
    int cyc, dones, wens, busy;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    cyc = 1;
    while (bus.res_raddr !== 8'd50 && cyc < 2000) begin
      tick;
      cyc++;
    end
    checks++;
    if (bus.res_raddr !== 8'd50) begin
      errors++;
      $display("FAIL midrst_reach50: res=%0d, need 50", bus.res_raddr);
    end
    tick;
    tick;
    reset = 1'b0;
    tick;
    check_idle_outputs("midrst_outputs");
    reset = 1'b1;
    dones = 0; wens = 0; busy = 0;
    for (int i = 0; i < 2100; i++) begin
      tick;
      if (bus.done) dones++;
      if (bus.y_wen) wens++;
      if (!bus.ready) busy++;
    end
    checks++;
    if (dones != 0 || wens != 0 || busy != 0) begin
      errors++;
      $display("FAIL midrst_quiet: dones=%0d wens=%0d busy=%0d, need 0/0/0",
               dones, wens, busy);
    end
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    checks++;
    if (bus.res_raddr !== 8'd0 || bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_restart: res=%0d ready=%b, need 0/0",
               bus.res_raddr, bus.ready);
    end
    tick;
    tick;
    checks++;
    if (bus.y_wen !== 1'b1 || bus.y_waddr !== 8'd0) begin
      errors++;
      $display("FAIL midrst_restart_write: wen=%b ywa=%0d, need 1/0",
               bus.y_wen, bus.y_waddr);
    end
    abort_frame;
  endtask

  task automatic test_back_to_back;
    int cyc, wens, oerr, ovl, dones;
    run_frame(1'b1, cyc, wens, oerr, ovl, dones);
    checks++;
    if (cyc != 2025 || dones != 1 || wens != 160 || oerr != 0 || ovl != 0) begin
      errors++;
      $display("FAIL b2b_frame: cycle=%0d dones=%0d wens=%0d oerr=%0d ovl=%0d, need 2025/1/160/0/0",
               cyc, dones, wens, oerr, ovl);
    end
    tick;
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle_gap: ready=%b, need 1", bus.ready);
    end
    tick;
    checks++;
    if (bus.ready !== 1'b0 || bus.res_raddr !== 8'd0 || bus.y_waddr !== 8'd159) begin
      errors++;
      $display("FAIL b2b_restart: ready=%b res=%0d ywa=%0d, need 0/0/159",
               bus.ready, bus.res_raddr, bus.y_waddr);
    end
    abort_frame;
  endtask

  initial begin
    bus.start = 1'b0;
    test_reset;
    test_first_sample;
    test_tap_sample;
    test_full_frame;
    test_mid_reset;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
